// File: rtl/input_debounce_4.sv
// -----------------------------------------------------------------------------
// input_debounce_4
//
// Input conditioning stage for the 4-input gate stage. Each of the four raw
// asynchronous inputs passes through a two-flop synchronizer. It is then
// debounced independently: a channel's debounced level changes only after the
// synchronized input has held the new value for STABLE_CYCLES qualified
// samples. A single-cycle rise or fall pulse accompanies each accepted change.
//
// Ports:
//   clk      in   1  clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   tick     in   1  sample-qualify strobe (tie high for per-cycle debounce)
//   raw_in   in   4  raw asynchronous inputs, bit i = channel i
//   in0..in3 out  1  debounced levels, channels 0..3
//   rise     out  4  one-cycle pulse when channel i is accepted 0->1
//   fall     out  4  one-cycle pulse when channel i is accepted 1->0
//   busy     out  1  some channel has a change pending (counter nonzero)
// -----------------------------------------------------------------------------
module input_debounce_4 #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [3:0] raw_in,
    output logic       in0,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic [3:0] rise,
    output logic [3:0] fall,
    output logic       busy
);

    // Last count value before a pending change is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer; only s2_q feeds the debounce logic.
    // ------------------------------------------------------------------
    logic [3:0] s1_q;
    logic [3:0] s1_d;
    logic [3:0] s2_q;
    logic [3:0] s2_d;

    always_comb begin
        s1_d = raw_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce
    // ------------------------------------------------------------------
    logic [3:0] db_vec;
    logic [3:0] rise_vec;
    logic [3:0] fall_vec;
    logic [3:0] pending_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             db_q;
            logic             db_d;
            logic             rise_q;
            logic             rise_d;
            logic             fall_q;
            logic             fall_d;

            always_comb begin
                cnt_d  = cnt_q;
                db_d   = db_q;
                rise_d = 1'b0;
                fall_d = 1'b0;
                if (s2_q[gi] == db_q) begin
                    // Input agrees with the output: any partial progress
                    // toward a change is discarded, tick or not.
                    cnt_d = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_MAX) begin
                        db_d   = s2_q[gi];
                        cnt_d  = '0;
                        rise_d = s2_q[gi];
                        fall_d = ~s2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q  <= '0;
                    db_q   <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    db_q   <= db_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                end
            end

            assign db_vec[gi]      = db_q;
            assign rise_vec[gi]    = rise_q;
            assign fall_vec[gi]    = fall_q;
            assign pending_vec[gi] = (cnt_q != '0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in0  = db_vec[0];
    assign in1  = db_vec[1];
    assign in2  = db_vec[2];
    assign in3  = db_vec[3];
    assign rise = rise_vec;
    assign fall = fall_vec;
    assign busy = |pending_vec;

endmodule
